issue_window_ctrl: RTL
======================

# issue_window_ctrl

Four-entry, age-ordered, collapsing issue window that owns the entry state consumed by `issue_pick_core`. It accepts dispatched micro-ops through a valid/ready handshake and tracks per-source readiness from writeback broadcasts and the pick core's ALU-forward hits. It retires the entry selected by the pick core's one-hot enable and compacts the window so that slot 0 always holds the oldest micro-op. Outputs are the packed per-slot vectors wired straight into `issue_pick_core`.

## Interface
- No parameters. Depth is fixed at 4 and ROB tags are 4 bits, matching the pick core.
- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low
- flush  in  1  kill all entries (branch-commit or snoop-hit recovery)
- d_valid  in  1  dispatch request
- d_ready  out  1  window can accept one micro-op this cycle
- d_src0_rob, d_src1_rob, d_dst_rob  in  4 each  source/destination ROB tags
- d_src0_rdy, d_src1_rdy  in  1 each  source ready at dispatch
- d_branch, d_load, d_store  in  1 each  instruction class
- d_pipe_alu, d_pipe_mul, d_pipe_mem, d_pipe_bru  in  1 each  target pipe, one-hot
- wb_valid  in  1  writeback broadcast
- wb_rob  in  4  ROB tag being written back
- p_en  in  4  one-hot picked slot from the pick core (0 = no pick)
- p_fwd_src0, p_fwd_src1  in  4 each  pick-core prepick forward hits, per slot
- w_valid  out  4  per-slot valid
- w_src0_rob, w_src1_rob, w_dst_rob  out  16 each  slot j in bits [4j+3:4j]
- w_src0_rdy, w_src1_rdy  out  4 each  per-slot source ready
- w_branch, w_load, w_store, w_pipe_alu, w_pipe_mul, w_pipe_mem, w_pipe_bru  out  4 each  per-slot fields
- count  out  3  occupied slots, 0..4

## Operation
- Invariant: valid slots are contiguous from slot 0, and slot index equals age rank (0 = oldest).
- Dispatch is accepted when `d_valid & d_ready`. `d_ready = (count != 4)` and is derived from registered state only. It does not look ahead to a same-cycle pick.
- Pick: if `p_en[k]` is set and `w_valid[k]` is 1, slot k is removed. Slots k+1..3 shift down by one and keep all their fields. A `p_en` bit that points at an invalid slot is ignored.
- Write slot for an accepted dispatch = `count - (pick ? 1 : 0)`. The new entry lands behind the survivors.
- Wakeup, applied to every surviving entry after the shift and to the incoming dispatch entry:
  - `srcX_rdy` becomes 1 if it was already 1, OR if `wb_valid` is set and `srcX_rob == wb_rob`, OR (surviving entries only) if `p_fwd_srcX` is set for the entry's pre-shift slot.
  - Ready bits never clear while an entry is resident.
- `count_next = count + accept - pick`.
- Flush has priority over everything. All valid bits clear, count goes to 0, and any same-cycle dispatch and pick are discarded. The wakeup state of discarded entries is irrelevant.
- Fields of invalid slots are don't-care, except `w_valid`, which must be 0.
- Reset: `w_valid = 0`, `count = 0`, `d_ready = 1`. The other outputs have no defined reset value.

## Timing
- All `w_*` outputs and `count` are registered.
- A micro-op accepted at edge N is visible in the window after edge N and pickable in the cycle following N.
- A pick presented in cycle N is removed at edge N+1. `p_en` is combinational from the `w_*` outputs through the pick core, with no loop back into the `w_*` registers within the same cycle.
- Wakeup latency: a `wb_valid` in cycle N sets the rdy bit at edge N+1. This includes a dispatch accepted in cycle N whose source matches `wb_rob`, so no wakeup is lost.
- Full window with a same-cycle pick: `d_ready` is 0, so no dispatch. Next cycle count = 3 and `d_ready` = 1. This one-cycle bubble is intentional.
- Reset asserted mid-operation clears state at the next edge, regardless of flush, dispatch or pick.

## Test plan
- Reset, then 4 back-to-back dispatches with dst tags 1, 2, 3, 4:
  - count goes 1, 2, 3, 4.
  - `d_ready` drops to 0 after the 4th accept.
  - `w_dst_rob = 16'h4321`.
- Full window, pick slot 1 (`p_en = 4'b0010`):
  - Next cycle count = 3 and `w_dst_rob[11:0] = 12'h431`.
  - `d_ready` = 1.
- Count = 2, pick slot 0 and dispatch tag 7 in the same cycle:
  - count stays 2.
  - Slot 0 holds the former slot 1.
  - Slot 1 holds tag 7.
- Slot 2 with `src0_rob = 5`, `src0_rdy = 0`; `wb_valid = 1`, `wb_rob = 5`; dispatch with `d_src1_rob = 5` in the same cycle:
  - After the edge, slot 2 `src0_rdy = 1` (slot 1 if a pick of slot 0 shifted it).
  - The new entry has `src1_rdy = 1`.
- `p_fwd_src1 = 4'b0100` while slot 0 is picked:
  - The shifted entry, now in slot 1, has `w_src1_rdy[1] = 1`.
- Count = 3, flush together with a dispatch and a pick:
  - Next cycle `w_valid = 0`, count = 0, `d_ready` = 1.
  - The dispatched entry is absent.

Source files
------------

// File: rtl/issue_window_ctrl_if.sv
// Dispatch channel into the issue window.
//   master: dispatcher, drives d_valid and the micro-op fields, samples d_ready
//   slave : issue window, samples the micro-op, drives d_ready
interface issue_window_ctrl_if;
    logic       d_valid;
    logic       d_ready;
    logic [3:0] d_src0_rob;
    logic [3:0] d_src1_rob;
    logic [3:0] d_dst_rob;
    logic       d_src0_rdy;
    logic       d_src1_rdy;
    logic       d_branch;
    logic       d_load;
    logic       d_store;
    logic       d_pipe_alu;
    logic       d_pipe_mul;
    logic       d_pipe_mem;
    logic       d_pipe_bru;

    modport master (
        output d_valid, d_src0_rob, d_src1_rob, d_dst_rob, d_src0_rdy, d_src1_rdy,
               d_branch, d_load, d_store, d_pipe_alu, d_pipe_mul, d_pipe_mem, d_pipe_bru,
        input  d_ready
    );

    modport slave (
        input  d_valid, d_src0_rob, d_src1_rob, d_dst_rob, d_src0_rdy, d_src1_rdy,
               d_branch, d_load, d_store, d_pipe_alu, d_pipe_mul, d_pipe_mem, d_pipe_bru,
        output d_ready
    );
endinterface

// File: rtl/issue_window_ctrl.sv
// Four-entry age-ordered collapsing issue window feeding issue_pick_core.
// Slot 0 always holds the oldest micro-op; valid slots are contiguous from 0.
// Ports:
//   clk, resetn (sync, active-low), flush
//   dsp            dispatch channel (valid/ready + micro-op fields)
//   wb_valid/wb_rob writeback broadcast used for source wakeup
//   p_en           one-hot pick from the pick core; picked slot is removed
//   p_fwd_src0/1   per-slot prepick forward hits (pre-shift slot index)
//   w_*            registered per-slot window state, slot j in bit j / [4j+3:4j]
//   count          registered occupancy 0..4
module issue_window_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    issue_window_ctrl_if.slave dsp,
    input  logic        wb_valid,
    input  logic [3:0]  wb_rob,
    input  logic [3:0]  p_en,
    input  logic [3:0]  p_fwd_src0,
    input  logic [3:0]  p_fwd_src1,
    output logic [3:0]  w_valid,
    output logic [15:0] w_src0_rob,
    output logic [15:0] w_src1_rob,
    output logic [15:0] w_dst_rob,
    output logic [3:0]  w_src0_rdy,
    output logic [3:0]  w_src1_rdy,
    output logic [3:0]  w_branch,
    output logic [3:0]  w_load,
    output logic [3:0]  w_store,
    output logic [3:0]  w_pipe_alu,
    output logic [3:0]  w_pipe_mul,
    output logic [3:0]  w_pipe_mem,
    output logic [3:0]  w_pipe_bru,
    output logic [2:0]  count
);
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned CNT_W = 3;

    typedef struct packed {
        logic [TAG_W-1:0] src0_rob;
        logic [TAG_W-1:0] src1_rob;
        logic [TAG_W-1:0] dst_rob;
        logic             src0_rdy;
        logic             src1_rdy;
        logic             branch;
        logic             load;
        logic             store;
        logic             pipe_alu;
        logic             pipe_mul;
        logic             pipe_mem;
        logic             pipe_bru;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_n [DEPTH];
    entry_t           new_e;
    logic [DEPTH-1:0] v_q, v_n;
    logic [CNT_W-1:0] count_q, count_n, cnt_surv;
    logic             d_ready_q;
    logic [DEPTH-1:0] pick_hit;
    logic             pick;
    logic [1:0]       pick_idx;
    logic             accept;
    logic [2:0]       src;

    // Ready bits are sticky: set by a matching writeback or a forward hit.
    function automatic entry_t wake(entry_t e, logic f0, logic f1,
                                    logic wbv, logic [TAG_W-1:0] wbr);
        entry_t r;
        r = e;
        r.src0_rdy = e.src0_rdy | f0 | (wbv && (e.src0_rob == wbr));
        r.src1_rdy = e.src1_rdy | f1 | (wbv && (e.src1_rob == wbr));
        return r;
    endfunction

    assign dsp.d_ready = d_ready_q;

    always_comb begin
        new_e.src0_rob = dsp.d_src0_rob;
        new_e.src1_rob = dsp.d_src1_rob;
        new_e.dst_rob  = dsp.d_dst_rob;
        new_e.src0_rdy = dsp.d_src0_rdy;
        new_e.src1_rdy = dsp.d_src1_rdy;
        new_e.branch   = dsp.d_branch;
        new_e.load     = dsp.d_load;
        new_e.store    = dsp.d_store;
        new_e.pipe_alu = dsp.d_pipe_alu;
        new_e.pipe_mul = dsp.d_pipe_mul;
        new_e.pipe_mem = dsp.d_pipe_mem;
        new_e.pipe_bru = dsp.d_pipe_bru;
    end

    // Next window: collapse the picked slot, wake survivors, append dispatch.
    always_comb begin
        pick_hit = p_en & v_q;
        pick     = |pick_hit;
        pick_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (pick_hit[i]) pick_idx = 2'(i);
        end
        accept   = dsp.d_valid & d_ready_q;
        cnt_surv = count_q - CNT_W'(pick);
        v_n      = '0;
        ent_n    = ent_q;
        src      = '0;
        for (int j = 0; j < DEPTH; j++) begin
            // Slots at or above the picked one pull from one slot higher.
            src = (pick && (3'(j) >= {1'b0, pick_idx})) ? 3'(j + 1) : 3'(j);
            if (3'(j) < cnt_surv) begin
                ent_n[j] = wake(ent_q[src[1:0]], p_fwd_src0[src[1:0]],
                                p_fwd_src1[src[1:0]], wb_valid, wb_rob);
                v_n[j]   = 1'b1;
            end
        end
        // Forward hits refer to resident slots only, never to the dispatch entry.
        if (accept) begin
            ent_n[cnt_surv[1:0]] = wake(new_e, 1'b0, 1'b0, wb_valid, wb_rob);
            v_n[cnt_surv[1:0]]   = 1'b1;
        end
        count_n = cnt_surv + CNT_W'(accept);
        if (flush) begin
            v_n     = '0;
            count_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            v_q       <= '0;
            count_q   <= '0;
            d_ready_q <= 1'b1;
        end else begin
            v_q       <= v_n;
            count_q   <= count_n;
            d_ready_q <= (count_n != CNT_W'(DEPTH));
        end
    end

    // Entry payload needs no reset; validity is carried by v_q.
    always_ff @(posedge clk) begin
        ent_q <= ent_n;
    end

    // Flatten registered entries onto the pick-core vectors.
    always_comb begin
        w_valid = v_q;
        count   = count_q;
        for (int j = 0; j < DEPTH; j++) begin
            w_src0_rob[4*j +: 4] = ent_q[j].src0_rob;
            w_src1_rob[4*j +: 4] = ent_q[j].src1_rob;
            w_dst_rob[4*j +: 4]  = ent_q[j].dst_rob;
            w_src0_rdy[j]        = ent_q[j].src0_rdy;
            w_src1_rdy[j]        = ent_q[j].src1_rdy;
            w_branch[j]          = ent_q[j].branch;
            w_load[j]            = ent_q[j].load;
            w_store[j]           = ent_q[j].store;
            w_pipe_alu[j]        = ent_q[j].pipe_alu;
            w_pipe_mul[j]        = ent_q[j].pipe_mul;
            w_pipe_mem[j]        = ent_q[j].pipe_mem;
            w_pipe_bru[j]        = ent_q[j].pipe_bru;
        end
    end
endmodule
